// File: rtl/adc_spi_responder_pkg.sv
// Shared definitions for the ADC serial register responder: frame FSM encoding,
// register-0 control bit positions and frame geometry.
package adc_spi_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } frame_state_e;

    localparam int READOUT_BIT = 0;
    localparam int SWRST_BIT   = 1;
    localparam int FRAME_BITS  = 16;
    localparam int ADDR_W      = 6;

    // An 8-bit frame address maps to a real register only if the upper two
    // bits are clear and it falls inside the implemented range.
    function automatic logic addr_impl(input logic [7:0] a, input int num_regs);
        return (a[7:6] == 2'b00) && (int'(a) < num_regs);
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for one asynchronous input bit, with a selectable
// reset value so idle-high lines come out of reset idle.
module cdc_sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_usb,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) ff <= {STAGES{RST_VAL}};
        else          ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/adc_spi_responder.sv
// Emulates the serial register port of an ADC: 8-bit address + 8-bit data
// write frames, register-0 controlled readout and software/hardware reset.
module adc_spi_responder
    import adc_spi_responder_pkg::*;
#(
    parameter int pSYNC_STAGES = 2,
    parameter int pNUM_REGS    = 64
) (
    input  logic              clk_usb,
    input  logic              reset_n,
    input  logic              ADC_RESET,
    input  logic              ADC_SEN,
    input  logic              ADC_SCLK,
    input  logic              ADC_SDATA,
    output logic              ADC_OVR_SDOUT,
    input  logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_data,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int FLUSH = pSYNC_STAGES + 1;
    localparam int FW    = $clog2(FLUSH + 1);

    logic sen_s, sclk_s, sdata_s, adc_rst_s;
    logic sen_d, sclk_d;

    cdc_sync_bit #(.STAGES(pSYNC_STAGES), .RST_VAL(1'b1)) u_sync_sen   (.clk_usb, .reset_n, .d(ADC_SEN),   .q(sen_s));
    cdc_sync_bit #(.STAGES(pSYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk  (.clk_usb, .reset_n, .d(ADC_SCLK),  .q(sclk_s));
    cdc_sync_bit #(.STAGES(pSYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (.clk_usb, .reset_n, .d(ADC_SDATA), .q(sdata_s));
    cdc_sync_bit #(.STAGES(pSYNC_STAGES), .RST_VAL(1'b0)) u_sync_rst   (.clk_usb, .reset_n, .d(ADC_RESET), .q(adc_rst_s));

    logic sen_fall, sen_rise, sclk_rise, sclk_fall;
    assign sen_fall  =  sen_d  & ~sen_s;
    assign sen_rise  = ~sen_d  &  sen_s;
    assign sclk_rise = ~sclk_d &  sclk_s;
    assign sclk_fall =  sclk_d & ~sclk_s;

    // After reset the synchronizers hold idle values; a low SEN pin would then
    // look like a falling edge, so frame starts wait until the chain has flushed.
    logic [FW-1:0] flush_cnt;
    logic          armed;
    assign armed = (flush_cnt == FW'(FLUSH));

    frame_state_e     state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [15:0]      shreg;
    logic [7:0]       rd_byte;
    logic [7:0]       regs [pNUM_REGS];

    logic start, shift_en, load_rd, commit, abort;
    logic readout, wr_ok, sw_rst;
    logic [7:0] waddr8, raddr8;

    assign readout = regs[0][READOUT_BIT];
    assign waddr8  = shreg[15:8];
    assign raddr8  = {shreg[6:0], sdata_s};
    assign wr_ok   = addr_impl(waddr8, pNUM_REGS) && (!readout || waddr8 == 8'h00);
    assign sw_rst  = (waddr8 == 8'h00) && shreg[SWRST_BIT];

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (adc_rst_s) state_nxt = ST_IDLE;
        else begin
            case (state)
                ST_IDLE: if (start) state_nxt = ST_ADDR;
                ST_ADDR: if (abort) state_nxt = ST_IDLE;
                         else if (load_rd) state_nxt = ST_DATA;
                ST_DATA: if (abort) state_nxt = ST_IDLE;
                         else if (shift_en && bit_cnt == CNT_W'(FRAME_BITS - 1)) state_nxt = ST_DONE;
                ST_DONE: if (commit) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // A start cycle never shifts, so a coincident SCLK rise is dropped.
    always_comb begin
        start    = 1'b0;
        shift_en = 1'b0;
        load_rd  = 1'b0;
        commit   = 1'b0;
        abort    = 1'b0;
        if (!adc_rst_s) begin
            case (state)
                ST_IDLE: start = sen_fall & armed;
                ST_ADDR: begin
                    abort    = sen_rise;
                    shift_en = sclk_rise & ~sen_rise;
                    load_rd  = shift_en && bit_cnt == CNT_W'(7);
                end
                ST_DATA: begin
                    abort    = sen_rise;
                    shift_en = sclk_rise & ~sen_rise;
                end
                ST_DONE: commit = sen_rise;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            sen_d         <= 1'b1;
            sclk_d        <= 1'b1;
            flush_cnt     <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            rd_byte       <= '0;
            ADC_OVR_SDOUT <= 1'b0;
            rf_data       <= '0;
            wr_stb        <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            frame_err     <= 1'b0;
        end else begin
            sen_d     <= sen_s;
            sclk_d    <= sclk_s;
            if (!armed) flush_cnt <= flush_cnt + 1'b1;
            if (start) bit_cnt <= '0;
            else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {shreg[14:0], sdata_s};
            end
            if (load_rd)
                rd_byte <= addr_impl(raddr8, pNUM_REGS) ? regs[raddr8[ADDR_W-1:0]] : 8'h00;
            // Data bit n is preceded by the falling edge seen at bit_cnt = 8+n.
            if (state != ST_DATA || !readout) ADC_OVR_SDOUT <= 1'b0;
            else if (sclk_fall)               ADC_OVR_SDOUT <= rd_byte[~bit_cnt[2:0]];
            rf_data   <= (int'(rf_addr) < pNUM_REGS) ? regs[rf_addr] : 8'h00;
            wr_stb    <= commit && wr_ok;
            frame_err <= abort;
            if (commit && wr_ok) begin
                wr_addr <= waddr8[ADDR_W-1:0];
                wr_data <= shreg[7:0];
            end
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < pNUM_REGS; i++) regs[i] <= '0;
        end else if (adc_rst_s || (commit && wr_ok && sw_rst)) begin
            for (int i = 0; i < pNUM_REGS; i++) regs[i] <= '0;
        end else if (commit && wr_ok) begin
            regs[waddr8[ADDR_W-1:0]] <= shreg[7:0];
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: write/read frames, aborts, readout mode,
// software reset, ADC_RESET and reset_n mid-frame.
module tb_adc_spi_responder;

    logic       clk_usb = 1'b0;
    logic       reset_n;
    logic       ADC_RESET, ADC_SEN, ADC_SCLK, ADC_SDATA;
    logic       ADC_OVR_SDOUT;
    logic [5:0] rf_addr;
    logic [7:0] rf_data;
    logic       wr_stb;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int stb_cnt = 0;
    int err_cnt = 0;

    always #5 clk_usb = ~clk_usb;

    adc_spi_responder #(.pSYNC_STAGES(2), .pNUM_REGS(64)) dut (
        .clk_usb(clk_usb), .reset_n(reset_n), .ADC_RESET(ADC_RESET),
        .ADC_SEN(ADC_SEN), .ADC_SCLK(ADC_SCLK), .ADC_SDATA(ADC_SDATA),
        .ADC_OVR_SDOUT(ADC_OVR_SDOUT), .rf_addr(rf_addr), .rf_data(rf_data),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
    );

    always @(negedge clk_usb) begin
        if (wr_stb)    stb_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_usb);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic s);
        ADC_SCLK  = 1'b0;
        ADC_SDATA = b;
        wait_cyc(5);
        s = ADC_OVR_SDOUT;
        wait_cyc(1);
        ADC_SCLK = 1'b1;
        wait_cyc(6);
    endtask

    // Bits past 16 are sent as 1 to show they are ignored.
    task automatic send_frame(input int nbits, input logic [15:0] w, output logic [7:0] rd);
        logic s;
        rd = '0;
        ADC_SEN = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < nbits; i++) begin
            send_bit((i < 16) ? w[15 - i] : 1'b1, s);
            if (i >= 8 && i < 16) rd[15 - i] = s;
        end
        ADC_SEN = 1'b1;
        wait_cyc(8);
    endtask

    task automatic rd_rf(input logic [5:0] a, output logic [7:0] d);
        rf_addr = a;
        wait_cyc(2);
        d = rf_data;
    endtask

    initial begin
        logic [7:0] rd, d;
        logic s;
        int s0, e0;
        reset_n = 1'b0; ADC_RESET = 1'b0; ADC_SEN = 1'b1; ADC_SCLK = 1'b1; ADC_SDATA = 1'b0;
        rf_addr = '0;
        wait_cyc(3);
        chk("rst_sdout", int'(ADC_OVR_SDOUT), 0);
        chk("rst_rf_data", int'(rf_data), 0);
        chk("rst_wr_stb", int'(wr_stb), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        reset_n = 1'b1;
        wait_cyc(6);

        // address 0x55 has bits[7:6]=01: no write
        s0 = stb_cnt; e0 = err_cnt;
        send_frame(16, 16'h55AA, rd);
        chk("hi_addr_stb", stb_cnt - s0, 0);
        chk("hi_addr_err", err_cnt - e0, 0);
        rd_rf(6'h15, d); chk("hi_addr_reg15", int'(d), 8'h00);

        s0 = stb_cnt;
        send_frame(16, 16'h15AA, rd);
        chk("wr15_stb", stb_cnt - s0, 1);
        chk("wr15_addr", int'(wr_addr), 6'h15);
        chk("wr15_data", int'(wr_data), 8'hAA);
        rd_rf(6'h15, d); chk("wr15_rf", int'(d), 8'hAA);

        // short frame, 11 bits
        s0 = stb_cnt; e0 = err_cnt;
        send_frame(11, 16'h1533, rd);
        chk("short_err", err_cnt - e0, 1);
        chk("short_stb", stb_cnt - s0, 0);
        rd_rf(6'h15, d); chk("short_reg15", int'(d), 8'hAA);

        // long frame, 20 bits
        s0 = stb_cnt; e0 = err_cnt;
        send_frame(20, 16'h203C, rd);
        chk("long_stb", stb_cnt - s0, 1);
        chk("long_err", err_cnt - e0, 0);
        rd_rf(6'h20, d); chk("long_reg20", int'(d), 8'h3C);

        // readout mode
        s0 = stb_cnt;
        send_frame(16, 16'h0001, rd);
        chk("ro_on_stb", stb_cnt - s0, 1);
        rd_rf(6'h00, d); chk("ro_reg0", int'(d), 8'h01);
        chk("ro_idle_sdout", int'(ADC_OVR_SDOUT), 0);
        s0 = stb_cnt;
        send_frame(16, 16'h1500, rd);
        chk("ro_read15", int'(rd), 8'hAA);
        chk("ro_wr_blocked", stb_cnt - s0, 0);
        rd_rf(6'h15, d); chk("ro_reg15_kept", int'(d), 8'hAA);
        send_frame(16, 16'h5500, rd);
        chk("ro_read_unimpl", int'(rd), 8'h00);

        // software reset
        s0 = stb_cnt;
        send_frame(16, 16'h0002, rd);
        chk("swrst_stb", stb_cnt - s0, 1);
        rd_rf(6'h15, d); chk("swrst_reg15", int'(d), 8'h00);
        rd_rf(6'h00, d); chk("swrst_reg0", int'(d), 8'h00);
        rd_rf(6'h20, d); chk("swrst_reg20", int'(d), 8'h00);

        // ADC_RESET pulse mid-frame
        send_frame(16, 16'h15AA, rd);
        rd_rf(6'h15, d); chk("reload_reg15", int'(d), 8'hAA);
        s0 = stb_cnt; e0 = err_cnt;
        ADC_SEN = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < 5; i++) send_bit(1'b1, s);
        ADC_RESET = 1'b1;
        wait_cyc(3);
        ADC_RESET = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < 3; i++) send_bit(1'b0, s);
        ADC_SEN = 1'b1;
        wait_cyc(8);
        chk("hwrst_err", err_cnt - e0, 0);
        chk("hwrst_stb", stb_cnt - s0, 0);
        rd_rf(6'h15, d); chk("hwrst_reg15", int'(d), 8'h00);

        // reset_n during DATA phase
        send_frame(16, 16'h15AA, rd);
        s0 = stb_cnt; e0 = err_cnt;
        ADC_SEN = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < 10; i++) send_bit(1'b1, s);
        reset_n = 1'b0;
        #1;
        chk("nrst_wr_addr", int'(wr_addr), 0);
        chk("nrst_wr_data", int'(wr_data), 0);
        chk("nrst_rf_data", int'(rf_data), 0);
        chk("nrst_sdout", int'(ADC_OVR_SDOUT), 0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(2);
        for (int i = 0; i < 6; i++) send_bit(1'b0, s);
        ADC_SEN = 1'b1;
        wait_cyc(8);
        chk("nrst_tail_stb", stb_cnt - s0, 0);
        chk("nrst_tail_err", err_cnt - e0, 0);
        send_frame(16, 16'h2A5C, rd);
        chk("nrst_next_stb", stb_cnt - s0, 1);
        chk("nrst_next_addr", int'(wr_addr), 6'h2A);
        chk("nrst_next_data", int'(wr_data), 8'h5C);
        rd_rf(6'h2A, d); chk("nrst_next_rf", int'(d), 8'h5C);
        rd_rf(6'h15, d); chk("nrst_reg15", int'(d), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
